// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared encodings for the memory stage.
//   memDataSize encodings, byte-lane count, FSM state type and the
//   alignment predicate used when MEM_ALIGN_CHECK_EN is defined.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int unsigned BYTE_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

  // Reserved size (2'b11) always counts as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = off[0];
      MEM_WORD: is_misaligned = (off != 2'b00);
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-addressed req/ack data bus.
//   master: drives bus_req, bus_we, bus_addr, bus_be, bus_wdata;
//           receives bus_ack, bus_rdata.
//   slave : the memory side of the same signals.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import mem_access_unit_pkg::*;

  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [BYTE_LANES-1:0] bus_be;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane logic (32-bit, 4 lanes).
//   st_size/st_off/st_data -> st_be, st_wdata   (store lane enables, replication)
//   ld_size/ld_off/ld_signed/ld_word -> ld_data (load extract and extend)
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]            st_size,
  input  logic [1:0]            st_off,
  input  logic [31:0]           st_data,
  output logic [BYTE_LANES-1:0] st_be,
  output logic [31:0]           st_wdata,
  input  logic [1:0]            ld_size,
  input  logic [1:0]            ld_off,
  input  logic                  ld_signed,
  input  logic [31:0]           ld_word,
  output logic [31:0]           ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = '1;
    st_wdata = st_data;
    case (st_size)
      MEM_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      MEM_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      MEM_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default:  ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access unit running one req/ack bus
// transaction per load/store, stalling the pipeline until completion.
//   clk, rst (sync, active-low)
//   memRead, memWrite, memIsSigned, memDataSize, addr, wdata : request
//   stall (combinational), rdata, rdata_valid, bus_err      : results
//   bus (mem_access_unit_if.master)                          : data bus
// Optional: `define MEM_ALIGN_CHECK_EN adds align_err and rejects
// misaligned half/word and reserved-size accesses without a bus cycle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memIsSigned,
  input  logic [1:0]            memDataSize,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  bus_err,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  align_err,
`endif
  mem_access_unit_if.master     bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic                  op_we;
  logic [1:0]            op_size;
  logic                  op_signed;
  logic [1:0]            op_off;
  logic                  req;
  logic [BYTE_LANES-1:0] st_be;
  logic [31:0]           st_wdata;
  logic [31:0]           ld_data;

  assign req = memRead | memWrite;

  // Store lanes come from the live request (capture in IDLE); the load
  // extract uses the captured op fields against the returning bus word.
  mem_lane_align u_lane (
    .st_size  (memDataSize),
    .st_off   (addr[1:0]),
    .st_data  (wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_size  (op_size),
    .ld_off   (op_off),
    .ld_signed(op_signed),
    .ld_word  (bus.bus_rdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    stall = ((state == ST_IDLE) && req) || (state == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      op_we         <= 1'b0;
      op_size       <= '0;
      op_signed     <= 1'b0;
      op_off        <= '0;
      rdata         <= '0;
      rdata_valid   <= 1'b0;
      bus_err       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err     <= 1'b0;
`endif
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_we     <= memWrite;
            op_size   <= memDataSize;
            op_signed <= memIsSigned;
            op_off    <= addr[1:0];
            cnt       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            if (is_misaligned(memDataSize, addr[1:0])) begin
              rdata     <= '0;
              align_err <= 1'b1;
              state     <= ST_DONE;
            end else
`endif
            begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= memWrite;
              bus.bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              bus.bus_be    <= st_be;
              bus.bus_wdata <= st_wdata;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!op_we) begin
              rdata       <= ld_data;
              rdata_valid <= 1'b1;
            end
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            bus.bus_req <= 1'b0;
            rdata       <= '0;
            bus_err     <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, memIsSigned;
  logic [1:0]  memDataSize;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, bus_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  mem_access_unit #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memIsSigned(memIsSigned),
    .memDataSize(memDataSize),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .bus_err    (bus_err),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err  (align_err),
`endif
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: byte-lane arithmetic on a little-endian 32-bit word.
  function automatic logic [31:0] model_load(logic [1:0] size, logic sgn, logic [31:0] a, logic [31:0] w);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] size, logic [31:0] a);
    if (size == 2'd0) return 4'(1 << (a % 4));
    if (size == 2'd1) return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(logic [1:0] size, logic [31:0] w);
    if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic model_misaligned(logic [1:0] size, logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // delay = index of the REQ cycle carrying bus_ack; delay >= TO means no ack.
  task automatic do_txn(input logic rd, input logic wr, input logic sgn, input logic [1:0] size,
                        input logic [31:0] a, input logic [31:0] w, input int unsigned delay,
                        input logic [31:0] rword, input string name);
    int unsigned stall_seen;
    int unsigned req_cycles;
    logic acked;
    logic is_wr;
    is_wr = wr;
    acked = 1'b0;
    stall_seen = 0;
    req_cycles = 0;
    @(negedge clk);
    memRead = rd; memWrite = wr; memIsSigned = sgn; memDataSize = size; addr = a; wdata = w;
    #1;
    if (stall === 1'b1) stall_seen++;
`ifdef MEM_ALIGN_CHECK_EN
    if (model_misaligned(size, a)) begin
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0;
      exp_rdata = 32'h0;
      tests++; if (align_err !== 1'b1) begin fails++; $display("FAIL %s align_err: got %b expected 1", name, align_err); end
      tests++; if (bus_if.bus_req !== 1'b0) begin fails++; $display("FAIL %s align bus_req: got %b expected 0", name, bus_if.bus_req); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL %s align stall: got %b expected 0", name, stall); end
      tests++; if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin fails++; $display("FAIL %s align rdata: got %b/%h expected 0/0", name, rdata_valid, rdata); end
      tests++; if (stall_seen != 1) begin fails++; $display("FAIL %s align stall_cycles: got %0d expected 1", name, stall_seen); end
      @(negedge clk);
      tests++; if (align_err !== 1'b0) begin fails++; $display("FAIL %s align_err pulse: got %b expected 0", name, align_err); end
      return;
    end
`endif
    for (int unsigned n = 0; n < TO; n++) begin
      @(negedge clk);
      req_cycles++;
      if (stall === 1'b1) stall_seen++;
      tests++; if (bus_if.bus_req !== 1'b1) begin fails++; $display("FAIL %s bus_req[%0d]: got %b expected 1", name, n, bus_if.bus_req); end
      tests++; if (bus_if.bus_we !== is_wr) begin fails++; $display("FAIL %s bus_we: got %b expected %b", name, bus_if.bus_we, is_wr); end
      tests++; if (bus_if.bus_addr !== (a & 32'hFFFF_FFFC)) begin fails++; $display("FAIL %s bus_addr: got %h expected %h", name, bus_if.bus_addr, a & 32'hFFFF_FFFC); end
      tests++; if (bus_if.bus_be !== model_be(size, a)) begin fails++; $display("FAIL %s bus_be: got %b expected %b", name, bus_if.bus_be, model_be(size, a)); end
      if (is_wr) begin
        tests++; if (bus_if.bus_wdata !== model_wdata(size, w)) begin fails++; $display("FAIL %s bus_wdata: got %h expected %h", name, bus_if.bus_wdata, model_wdata(size, w)); end
      end
      if (n == delay) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rword; acked = 1'b1;
      end else begin
        bus_if.bus_rdata = $urandom;
      end
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      if (acked) break;
    end
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0;
    if (!acked) exp_rdata = 32'h0;
    else if (!is_wr) exp_rdata = model_load(size, sgn, a, rword);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL %s done stall: got %b expected 0", name, stall); end
    tests++; if (bus_if.bus_req !== 1'b0) begin fails++; $display("FAIL %s done bus_req: got %b expected 0", name, bus_if.bus_req); end
    tests++; if (rdata_valid !== (acked && !is_wr)) begin fails++; $display("FAIL %s rdata_valid: got %b expected %b", name, rdata_valid, acked && !is_wr); end
    tests++; if (bus_err !== !acked) begin fails++; $display("FAIL %s bus_err: got %b expected %b", name, bus_err, !acked); end
    tests++; if (rdata !== exp_rdata) begin fails++; $display("FAIL %s rdata: got %h expected %h", name, rdata, exp_rdata); end
    tests++; if (stall_seen != req_cycles + 1) begin fails++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_seen, req_cycles + 1); end
    tests++; if (req_cycles != (acked ? delay + 1 : TO)) begin fails++; $display("FAIL %s req_cycles: got %0d expected %0d", name, req_cycles, acked ? delay + 1 : TO); end
    @(negedge clk);
    tests++; if (rdata_valid !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL %s after_done: got v=%b e=%b s=%b expected 0/0/0", name, rdata_valid, bus_err, stall); end
    tests++; if (rdata !== exp_rdata) begin fails++; $display("FAIL %s rdata_hold: got %h expected %h", name, rdata, exp_rdata); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (stall !== 1'b0 || rdata_valid !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL reset_flags: got s=%b v=%b e=%b expected 0", stall, rdata_valid, bus_err); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    tests++; if (bus_if.bus_req !== 1'b0 || bus_if.bus_we !== 1'b0) begin fails++; $display("FAIL reset_req_we: got %b%b expected 00", bus_if.bus_req, bus_if.bus_we); end
    tests++; if (bus_if.bus_addr !== 32'h0 || bus_if.bus_be !== 4'h0 || bus_if.bus_wdata !== 32'h0) begin fails++; $display("FAIL reset_bus: got %h %h %h expected 0", bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata); end
`ifdef MEM_ALIGN_CHECK_EN
    tests++; if (align_err !== 1'b0) begin fails++; $display("FAIL reset_align_err: got %b expected 0", align_err); end
`endif
    rst = 1'b1;
    exp_rdata = 32'h0;
  endtask

  task automatic test_byte_signed_load();
    do_txn(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'h0, 0, 32'h80AA_BBCC, "byte_signed_load");
  endtask

  task automatic test_half_unsigned_load();
    do_txn(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_2002, 32'h0, 1, 32'h9ABC_1234, "half_unsigned_load");
  endtask

  task automatic test_byte_store();
    do_txn(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_3001, 32'h0000_00A5, 4, 32'h0, "byte_store");
  endtask

  task automatic test_write_wins();
    do_txn(1'b1, 1'b1, 1'b1, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF, 2, 32'h1234_5678, "write_wins");
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_5004, 32'h0, TO, 32'h0, "timeout");
  endtask

  task automatic test_misaligned();
    do_txn(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_6003, 32'h0, 0, 32'hF00D_8001, "half_misaligned");
    do_txn(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0002, 32'h0, 0, 32'hCAFE_F00D, "word_misaligned");
    do_txn(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_7001, 32'h1122_3344, 0, 32'h0, "reserved_store");
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    memRead = 1'b1; memWrite = 1'b0; memIsSigned = 1'b0; memDataSize = 2'b10; addr = 32'h0000_8000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; memRead = 1'b0;
    @(negedge clk);
    exp_rdata = 32'h0;
    tests++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL midreset_req_stall: got %b/%b expected 0/0", bus_if.bus_req, stall); end
    tests++; if (rdata !== 32'h0 || bus_if.bus_addr !== 32'h0 || bus_if.bus_be !== 4'h0) begin fails++; $display("FAIL midreset_outputs: got %h %h %h expected 0", rdata, bus_if.bus_addr, bus_if.bus_be); end
    rst = 1'b1;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (rdata_valid !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0) begin fails++; $display("FAIL late_ack: got v=%b r=%h s=%b expected 0/0/0", rdata_valid, rdata, stall); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic rd, wr, sgn;
      logic [1:0] size;
      logic [31:0] a;
      int unsigned dly;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      sgn = 1'($urandom);
      size = 2'($urandom);
      a = $urandom;
      dly = (i % 8 == 7) ? TO : $urandom_range(0, TO - 1);
      do_txn(rd, wr, sgn, size, a, $urandom, dly, $urandom, "random");
    end
  endtask

  initial begin
    rst = 1'b0; memRead = 1'b0; memWrite = 1'b0; memIsSigned = 1'b0; memDataSize = 2'b00;
    addr = 32'h0; wdata = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    test_reset();
    test_byte_signed_load();
    test_half_unsigned_load();
    test_byte_store();
    test_write_wins();
    test_timeout();
    test_misaligned();
    test_reset_mid_req();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
